spi_sub_param: RTL and testbench
================================

Name: spi_sub_param

Overview:
- Parametrised SPI subordinate. Successor to the fixed 44-bit spi_sub.
- Deserialises a command frame {op, addr, data} from mosi and issues single-cycle memory strobes on the memory-side bus.
- Serialises a response frame back on miso.
- Adds generic address/data widths, an auto-incrementing burst-read mode, reserved-opcode error handling, and an explicit synchronous reset. Sits between the SPI pads and the on-chip memory/register bank.

Parameters:
- ADDR_W, 10: address field and addr port width.
- DATA_W, 32: data field and data port width.
- BURST_LEN, 4: words read by a burst-read command (>=2).

Ports:
- sclk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cs_n  input  1  chip select, active low, sampled on sclk rising edge.
- mosi  input  1  serial command in, MSB first.
- miso  output  1  serial response out, MSB first, registered.
- r_en  output  1  memory read strobe, one cycle per word.
- w_en  output  1  memory write strobe, one cycle.
- addr  output  ADDR_W  memory address.
- data_o  output  DATA_W  write data.
- data_i  input  DATA_W  read data; combinational memory, valid in the same cycle as r_en.
- frame_err  output  1  one-cycle pulse on reserved opcode.

Behaviour:
- Frame width: FW = 2+ADDR_W+DATA_W (44 at defaults). Command layout {op[1:0], addr, data}, MSB first.
- Opcodes: 00 read, 01 write, 11 burst read, 10 reserved.
- Reset (rst_n=0 at a rising edge): has priority over everything. State IDLE; miso, r_en, w_en, frame_err = 0; addr, data_o = 0; shift register, bit counter and burst buffer cleared.
- cs_n=1 at any rising edge: synchronous abort.
  - Next state IDLE, counters cleared, miso=0, r_en=w_en=0.
  - Strobes not yet issued are never issued.
  - A strobe already registered for the current cycle completes.
- State SEL: first rising edge with cs_n=0 in IDLE enters SEL. mosi is ignored at this edge (turnaround cycle).
- State SHIFT: the next FW rising edges each shift mosi in, MSB first.
- At the edge sampling the last bit, the next state is chosen by op:
  - 01: MEM. w_en=1, addr=field, data_o=field for exactly one cycle.
  - 00: MEM. r_en=1, addr=field for one cycle; data_i captured at the closing edge.
  - 11: BURST. r_en=1 for BURST_LEN consecutive cycles. addr = base+k for k=0..BURST_LEN-1, wrapping modulo 2^ADDR_W. data_i captured into buffer[k] at each closing edge. The command's data field is ignored.
  - 10: ERR. No strobe. frame_err=1 for one cycle.
- addr and data_o hold their last values after the strobe.
- State RESP: begins the cycle after the last strobe (or after the ERR cycle). miso presents one bit per cycle, MSB first. Response content:
  - Read: {op, addr, read data}, FW bits.
  - Write: {op, addr, written data}, FW bits.
  - Reserved: {2'b10, addr, all-ones}, FW bits.
  - Burst: {2'b11, base addr, buffer[0], ..., buffer[BURST_LEN-1]}, 2+ADDR_W+BURST_LEN*DATA_W bits.
- State DONE: after the last response bit, miso=0 and no further activity until cs_n is sampled high (then IDLE). A new frame requires cs_n to deassert and reassert.
- Latency, single op: strobe cycle = FW+1 edges after SEL; first response bit in the following cycle.

Test Plan:
- Write: rst_n low 2 cycles, then frame {01, 0x222, 0xDEADBEEF} -> exactly one w_en cycle with addr=0x222, data_o=0xDEADBEEF, r_en never high; next 44 miso bits equal the command frame.
- Read: data_i model returns 0xA5A5_0000|addr; frame {00, 0x011, 0} -> one r_en cycle at addr 0x011; miso returns {00, 0x011, 0xA5A50011}.
- Burst read with wrap: frame {11, 0x3FE, x} -> r_en high 4 consecutive cycles, addr 0x3FE, 0x3FF, 0x000, 0x001; miso returns 12-bit header then 0xA5A503FE, 0xA5A503FF, 0xA5A50000, 0xA5A50001.
- Abort mid-frame: cs_n high after 20 bits of {01, 0x111, 0x12345678} -> no r_en/w_en; a subsequent full write to 0x222 behaves exactly as the write scenario.
- Reserved opcode: frame {10, 0x055, 0x1} -> frame_err pulses once, no strobe; miso returns {10, 0x055, 0xFFFFFFFF}.
- Reset mid-burst: rst_n low during the second r_en cycle -> all outputs 0 at the next edge; no further r_en; miso stays 0.

Source files
------------

// File: rtl/spi_sub_param.sv
// spi_sub_param: parametrised SPI subordinate.
// Receives a {op, addr, data} command frame on mosi (MSB first), issues
// single-cycle memory strobes (read, write, or an auto-incrementing burst
// read) and returns a response frame on miso (MSB first).
// Handshake: r_en / w_en are one-cycle strobes with no back-pressure; the
// memory is combinational, so data_i is valid in the same cycle as r_en and
// is captured at the edge that closes that cycle.
module spi_sub_param #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              r_en,
   output logic              w_en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              frame_err,
   output logic [2:0]        dbg_state
);

   // command frame width and longest response (burst) width
   localparam int FW   = 2 + ADDR_W + DATA_W;
   localparam int RW   = 2 + ADDR_W + BURST_LEN * DATA_W;
   localparam int PADW = RW - FW;
   localparam int BUFW = (BURST_LEN - 1) * DATA_W;
   localparam int CW   = $clog2(RW + 1);
   localparam int KW   = $clog2(BURST_LEN);

   localparam logic [CW-1:0] C_LAST_BIT    = CW'(FW - 1);
   localparam logic [CW-1:0] C_SINGLE_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] C_BURST_LAST  = CW'(RW - 1);
   localparam logic [KW-1:0] K_LAST        = KW'(BURST_LEN - 1);

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RSV = 2'b10;
   localparam logic [1:0] OP_BRD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_SHIFT = 3'd2,
      S_MEM   = 3'd3,
      S_BURST = 3'd4,
      S_ERR   = 3'd5,
      S_RESP  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t              r_state;
   logic [FW-2:0]       r_sr;      // first FW-1 command bits; the last comes straight from mosi
   logic [CW-1:0]       r_cnt;     // command bit counter, then remaining response bits
   logic [KW-1:0]       r_k;       // burst word index
   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_base;    // command address field, echoed in the response
   logic [BUFW-1:0]     r_buf;     // burst words captured so far, oldest in the MSBs
   logic [RW-1:0]       r_resp;    // response bits still to send, left-aligned
   logic                r_miso;
   logic                r_ren;
   logic                r_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_ferr;

   logic [FW-1:0]       w_frame;
   logic [1:0]          w_op;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;
   logic [BUFW+DATA_W-1:0] w_buf_next;
   logic [DATA_W-1:0]   w_word;
   logic [RW-1:0]       w_load;
   logic [CW-1:0]       w_load_last;

   // complete command frame as seen at the edge that samples the last bit
   assign w_frame = {r_sr, mosi};
   assign w_op    = w_frame[FW-1 -: 2];
   assign w_addr  = w_frame[DATA_W +: ADDR_W];
   assign w_data  = w_frame[DATA_W-1:0];

   // burst buffer including the word being read this cycle
   assign w_buf_next = {r_buf, data_i};

   // single-op response word: live read data for reads, written data otherwise
   assign w_word = (r_op == OP_RD) ? data_i : r_data;

   // response selection and length, chosen by the state that precedes RESP
   always_comb begin
      w_load      = {r_op, r_base, w_word, {PADW{1'b0}}};
      w_load_last = C_SINGLE_LAST;
      if (r_state == S_BURST) begin
         w_load      = {OP_BRD, r_base, w_buf_next};
         w_load_last = C_BURST_LAST;
      end else if (r_state == S_ERR) begin
         w_load      = {OP_RSV, r_base, {DATA_W{1'b1}}, {PADW{1'b0}}};
         w_load_last = C_SINGLE_LAST;
      end
   end

   // frame FSM: reset, chip-select abort, shift, strobe, respond
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
         r_op    <= '0;
         r_base  <= '0;
         r_buf   <= '0;
         r_resp  <= '0;
         r_miso  <= 1'b0;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ferr  <= 1'b0;
      end else if (cs_n) begin
         // abort: pending strobes are dropped, the one already on the bus completes
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
         r_miso  <= 1'b0;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // turnaround edge: mosi is not sampled here
               r_state <= S_SEL;
               r_cnt   <= '0;
            end

            S_SEL, S_SHIFT: begin
               r_sr <= w_frame[FW-2:0];
               if (r_cnt == C_LAST_BIT) begin
                  r_cnt  <= '0;
                  r_op   <= w_op;
                  r_base <= w_addr;
                  case (w_op)
                     OP_WR: begin
                        r_wen   <= 1'b1;
                        r_addr  <= w_addr;
                        r_data  <= w_data;
                        r_state <= S_MEM;
                     end
                     OP_RD: begin
                        r_ren   <= 1'b1;
                        r_addr  <= w_addr;
                        r_state <= S_MEM;
                     end
                     OP_BRD: begin
                        r_ren   <= 1'b1;
                        r_addr  <= w_addr;
                        r_k     <= '0;
                        r_state <= S_BURST;
                     end
                     default: begin
                        r_ferr  <= 1'b1;
                        r_state <= S_ERR;
                     end
                  endcase
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_SHIFT;
               end
            end

            S_MEM: begin
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
               r_miso  <= w_load[RW-1];
               r_resp  <= {w_load[RW-2:0], 1'b0};
               r_cnt   <= w_load_last;
               r_state <= S_RESP;
            end

            S_BURST: begin
               r_buf <= w_buf_next[BUFW-1:0];
               if (r_k == K_LAST) begin
                  r_ren   <= 1'b0;
                  r_miso  <= w_load[RW-1];
                  r_resp  <= {w_load[RW-2:0], 1'b0};
                  r_cnt   <= w_load_last;
                  r_state <= S_RESP;
               end else begin
                  // address wraps naturally at ADDR_W bits
                  r_k    <= r_k + 1'b1;
                  r_addr <= r_addr + 1'b1;
               end
            end

            S_ERR: begin
               r_ferr  <= 1'b0;
               r_miso  <= w_load[RW-1];
               r_resp  <= {w_load[RW-2:0], 1'b0};
               r_cnt   <= w_load_last;
               r_state <= S_RESP;
            end

            S_RESP: begin
               if (r_cnt == '0) begin
                  r_miso  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_miso <= r_resp[RW-1];
                  r_resp <= {r_resp[RW-2:0], 1'b0};
                  r_cnt  <= r_cnt - 1'b1;
               end
            end

            default: begin
               // DONE: wait for cs_n to be released
               r_miso  <= 1'b0;
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign miso      = r_miso;
   assign r_en      = r_ren;
   assign w_en      = r_wen;
   assign addr      = r_addr;
   assign data_o    = r_data;
   assign frame_err = r_ferr;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_sub_param.sv
// Testbench for spi_sub_param: scenario tasks drive frames, a strobe
// scoreboard checks every memory strobe, and response bits are checked
// against a queue filled when each frame is sent.
module tb_spi_sub_param;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 4;
   localparam int FW        = 2 + ADDR_W + DATA_W;
   localparam int RW        = 2 + ADDR_W + BURST_LEN * DATA_W;
   localparam int SW        = 1 + ADDR_W + DATA_W;

   // ---------------- clock / reset ----------------
   logic              sclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cs_n = 1'b1;
   logic              mosi = 1'b0;
   logic              miso;
   logic              r_en;
   logic              w_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] data_i;
   logic              frame_err;
   logic [2:0]        dbg_state;

   always #5 sclk = ~sclk;

   // combinational memory model
   assign data_i = 32'hA5A5_0000 | {{(DATA_W-ADDR_W){1'b0}}, addr};

   spi_sub_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .r_en(r_en), .w_en(w_en), .addr(addr), .data_o(data_o), .data_i(data_i),
      .frame_err(frame_err), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   int err_seen = 0;
   logic [SW-1:0] strobe_q[$];   // {is_write, addr, data (0 for reads)}
   logic [0:0]    resp_q[$];     // expected miso bits in order

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return 32'hA5A5_0000 | {{(DATA_W-ADDR_W){1'b0}}, a};
   endfunction

   task automatic push_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) resp_q.push_back(v[i]);
   endtask

   task automatic push_strobe(input logic is_w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
      strobe_q.push_back({is_w, a, d});
   endtask

   // strobe monitor: every strobe seen on the bus must match the next expected one
   always @(negedge sclk) begin
      logic [SW-1:0] e;
      logic [SW-1:0] got;
      if (r_en === 1'b1 || w_en === 1'b1) begin
         tests++;
         got = {w_en, addr, (w_en === 1'b1) ? data_o : {DATA_W{1'b0}}};
         if (strobe_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got r_en=%b w_en=%b addr=%h data_o=%h, required no strobe",
                     r_en, w_en, addr, data_o);
         end else begin
            e = strobe_q.pop_front();
            if (got !== e || (r_en === 1'b1 && w_en === 1'b1)) begin
               fails++;
               $display("FAIL strobe: got r_en=%b w_en=%b {w,addr,data}=%h, required %h",
                        r_en, w_en, got, e);
            end
         end
      end
      if (frame_err === 1'b1) err_seen++;
   end

   // ---------------- driver tasks ----------------
   task automatic send_frame(input logic [FW-1:0] f);
      @(negedge sclk);
      cs_n = 1'b0;
      mosi = 1'b0;
      for (int i = FW - 1; i >= 0; i--) begin
         @(negedge sclk);
         mosi = f[i];
      end
   endtask

   // checks strobe-slot timing, then each response bit, then idle miso
   task automatic collect_resp(input int slots, input int rlen, input string name);
      logic       e_bit;
      logic       e_act;
      logic       act;
      for (int c = 0; c < slots + rlen + 4; c++) begin
         @(negedge sclk);
         act   = r_en | w_en | frame_err;
         e_act = (c < slots);
         e_bit = 1'b0;
         if (c >= slots && c < slots + rlen) begin
            if (resp_q.size() != 0) e_bit = resp_q.pop_front();
         end
         tests++;
         if ({act, miso} !== {e_act, e_bit}) begin
            fails++;
            $display("FAIL %s cycle %0d: got strobe_active=%b miso=%b, required strobe_active=%b miso=%b",
                     name, c, act, miso, e_act, e_bit);
         end
      end
      cs_n = 1'b1;
      @(negedge sclk);
      @(negedge sclk);
      tests++;
      if (strobe_q.size() != 0 || resp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_leftover: got %0d strobes and %0d bits still expected, required 0 and 0",
                  name, strobe_q.size(), resp_q.size());
         strobe_q.delete();
         resp_q.delete();
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      cs_n  = 1'b1;
      @(negedge sclk);
      @(negedge sclk);
      tests++;
      if ({miso, r_en, w_en, frame_err, addr, data_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got miso=%b r_en=%b w_en=%b frame_err=%b addr=%h data_o=%h, required all 0",
                  miso, r_en, w_en, frame_err, addr, data_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write(input bit do_reset);
      logic [FW-1:0] f;
      int            e0;
      if (do_reset) begin
         rst_n = 1'b0;
         cs_n  = 1'b1;
         @(negedge sclk);
         @(negedge sclk);
         rst_n = 1'b1;
      end
      f  = {2'b01, 10'h222, 32'hDEADBEEF};
      e0 = err_seen;
      push_strobe(1'b1, 10'h222, 32'hDEADBEEF);
      push_bits({20'd0, f}, FW);
      send_frame(f);
      collect_resp(1, FW, "write");
      tests++;
      if (err_seen !== e0 || addr !== 10'h222 || data_o !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL write_hold: got frame_err pulses=%0d addr=%h data_o=%h, required 0 222 deadbeef",
                  err_seen - e0, addr, data_o);
      end
   endtask

   task automatic test_read();
      logic [FW-1:0] f;
      f = {2'b00, 10'h011, 32'h0};
      push_strobe(1'b0, 10'h011, '0);
      push_bits({20'd0, 2'b00, 10'h011, mem_word(10'h011)}, FW);
      send_frame(f);
      collect_resp(1, FW, "read");
   endtask

   task automatic test_burst_wrap();
      logic [FW-1:0]     f;
      logic [ADDR_W-1:0] a;
      f = {2'b11, 10'h3FE, 32'h1234_5678};
      push_bits({52'd0, 2'b11, 10'h3FE}, 2 + ADDR_W);
      for (int k = 0; k < BURST_LEN; k++) begin
         a = 10'h3FE + ADDR_W'(k);
         push_strobe(1'b0, a, '0);
         push_bits({32'd0, mem_word(a)}, DATA_W);
      end
      send_frame(f);
      collect_resp(BURST_LEN, RW, "burst");
   endtask

   task automatic test_reserved();
      logic [FW-1:0] f;
      int            e0;
      f  = {2'b10, 10'h055, 32'h1};
      e0 = err_seen;
      push_bits({20'd0, 2'b10, 10'h055, 32'hFFFF_FFFF}, FW);
      send_frame(f);
      collect_resp(1, FW, "reserved");
      tests++;
      if (err_seen - e0 !== 1) begin
         fails++;
         $display("FAIL reserved_err_count: got %0d frame_err pulses, required 1", err_seen - e0);
      end
   endtask

   task automatic test_abort();
      logic [FW-1:0] f;
      f = {2'b01, 10'h111, 32'h1234_5678};
      @(negedge sclk);
      cs_n = 1'b0;
      mosi = 1'b0;
      for (int i = FW - 1; i >= FW - 20; i--) begin
         @(negedge sclk);
         mosi = f[i];
      end
      @(negedge sclk);
      cs_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge sclk);
         tests++;
         if ({r_en, w_en, miso} !== 3'b000) begin
            fails++;
            $display("FAIL abort_quiet cycle %0d: got r_en=%b w_en=%b miso=%b, required 0 0 0",
                     c, r_en, w_en, miso);
         end
      end
      test_write(1'b0);
   endtask

   task automatic test_reset_mid_burst();
      logic [FW-1:0] f;
      f = {2'b11, 10'h3FE, 32'h0};
      push_strobe(1'b0, 10'h3FE, '0);
      push_strobe(1'b0, 10'h3FF, '0);
      send_frame(f);
      @(negedge sclk);   // first r_en cycle
      @(negedge sclk);   // second r_en cycle: assert reset now
      tests++;
      if (r_en !== 1'b1 || addr !== 10'h3FF) begin
         fails++;
         $display("FAIL rmb_second_strobe: got r_en=%b addr=%h, required 1 3ff", r_en, addr);
      end
      rst_n = 1'b0;
      cs_n  = 1'b1;
      @(negedge sclk);
      tests++;
      if ({miso, r_en, w_en, frame_err, addr, data_o} !== '0) begin
         fails++;
         $display("FAIL rmb_outputs: got miso=%b r_en=%b w_en=%b frame_err=%b addr=%h data_o=%h, required all 0",
                  miso, r_en, w_en, frame_err, addr, data_o);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge sclk);
         tests++;
         if ({r_en, w_en, miso} !== 3'b000) begin
            fails++;
            $display("FAIL rmb_quiet cycle %0d: got r_en=%b w_en=%b miso=%b, required 0 0 0",
                     c, r_en, w_en, miso);
         end
      end
      tests++;
      if (strobe_q.size() != 0) begin
         fails++;
         $display("FAIL rmb_leftover: got %0d strobes still expected, required 0", strobe_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write(1'b1);
      test_read();
      test_burst_wrap();
      test_reserved();
      test_abort();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule
